led_matrix_scanner: RTL and testbench

Parametrised LED matrix scan driver, the next generation of our 4x8 row-scan driver. Adds per-pixel grey-scale PWM, a double-buffered framebuffer with a random-access write port and frame-synchronous swap, programmable inter-row blanking (ghosting suppression), and configurable drive polarity. Sits between the application logic and the board LED row/column pins.

---
 rtl/led_pkg.sv | 23 ++
 rtl/led_matrix_scanner_if.sv | 35 +++
 rtl/led_scan_timer.sv | 67 ++++++
 rtl/led_matrix_scanner.sv | 148 ++++++++++++++
 tb/tb_led_matrix_scanner.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared helpers for the LED matrix scanner: address-width and idle-level
// functions plus the default geometry of the matrix.
package led_pkg;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 8;
  localparam int DEF_BPP  = 3;

  // One pixel at the default brightness depth.
  typedef logic [DEF_BPP-1:0] pixel_t;

  // Bits needed to index n items. Never less than 1, so a single-row
  // matrix still gets a legal vector.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Pin level that means "not driven". Active-low pins idle high.
  function automatic logic idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Application-side bus of the LED matrix scanner: random-access back-buffer
// write port and the frame-swap request/status pair.
interface led_matrix_scanner_if
  import led_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int BPP  = DEF_BPP
) ();

  localparam int RAW = addr_w(ROWS);
  localparam int CAW = addr_w(COLS);

  // Handshake: wr_en and swap_req are strobes with no ready. Every cycle in
  // which a strobe is high is taken by the scanner on that clock edge.
  // swap_pending is status only: it is high from the edge after a swap_req
  // is taken until the edge on which the swap is performed.
  logic           wr_en;
  logic [RAW-1:0] wr_row;
  logic [CAW-1:0] wr_col;
  logic [BPP-1:0] wr_data;
  logic           swap_req;
  logic           swap_pending;

  modport master (
    output wr_en, wr_row, wr_col, wr_data, swap_req,
    input  swap_pending
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, swap_req,
    output swap_pending
  );

endinterface

// File: rtl/led_scan_timer.sv
// Scan timing for the LED matrix: prescaler, PWM slot and row counters.
// All counters sit at zero while enable is low, so re-enabling always
// restarts at the top of a frame.
module led_scan_timer
  import led_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int BPP         = DEF_BPP,
  parameter int PRESCALE    = 64,
  parameter int BLANK_SLOTS = 2,
  localparam int SLOTS      = BLANK_SLOTS + (1 << BPP),
  localparam int RAW        = addr_w(ROWS),
  localparam int SW         = addr_w(SLOTS)
) (
  input  logic           clk12MHz,
  input  logic           reset_n,
  input  logic           enable,
  output logic [RAW-1:0] row,
  output logic [SW-1:0]  slot,
  output logic           is_blank,
  output logic           frame_end,
  output logic           frame_begin
);

  localparam int PW = addr_w(PRESCALE);

  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]  SLOT_LAST  = SW'(SLOTS - 1);
  localparam logic [RAW-1:0] ROW_LAST   = RAW'(ROWS - 1);
  localparam logic [SW-1:0]  BLANK_END  = SW'(BLANK_SLOTS);

  logic [PW-1:0] presc;
  logic          presc_wrap;
  logic          slot_wrap;
  logic          row_wrap;

  assign presc_wrap = (presc == PRESC_LAST);
  assign slot_wrap  = (slot == SLOT_LAST);
  assign row_wrap   = (row == ROW_LAST);

  // Status decoded from the current counter state.
  assign is_blank    = (slot < BLANK_END);
  assign frame_end   = enable & presc_wrap & slot_wrap & row_wrap;
  assign frame_begin = enable & (presc == '0) & (slot == '0) & (row == '0);

  // Cascaded counters: slot steps on prescaler wrap, row steps on slot wrap.
  always_ff @(posedge clk12MHz or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      slot  <= '0;
      row   <= '0;
    end else if (!enable) begin
      presc <= '0;
      slot  <= '0;
      row   <= '0;
    end else begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
      if (presc_wrap) begin
        slot <= slot_wrap ? '0 : slot + 1'b1;
        if (slot_wrap) begin
          row <= row_wrap ? '0 : row + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// LED matrix row-scan driver with per-pixel grey-scale PWM, a double-buffered
// framebuffer swapped on frame boundaries, inter-row blanking and
// configurable pin polarity. Every pin output is registered.
module led_matrix_scanner
  import led_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int BPP            = DEF_BPP,
  parameter int PRESCALE       = 64,
  parameter int BLANK_SLOTS    = 2,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk12MHz,
  input  logic                  reset_n,
  input  logic                  enable,
  led_matrix_scanner_if.slave   bus,
  output logic                  frame_start,
  output logic [ROWS-1:0]       row_out,
  output logic [COLS-1:0]       col_out
);

  localparam int SLOTS = BLANK_SLOTS + (1 << BPP);
  localparam int RAW   = addr_w(ROWS);
  localparam int CAW   = addr_w(COLS);
  localparam int SW    = addr_w(SLOTS);

  localparam logic ROW_IDLE_BIT = idle_level(ROW_ACTIVE_LOW);
  localparam logic COL_IDLE_BIT = idle_level(COL_ACTIVE_LOW);
  localparam logic [ROWS-1:0] ROW_IDLE = {ROWS{ROW_IDLE_BIT}};
  localparam logic [COLS-1:0] COL_IDLE = {COLS{COL_IDLE_BIT}};

  // One extra bit so non-power-of-two limits compare without wrapping.
  localparam logic [RAW:0] ROW_LIM = (RAW + 1)'(ROWS);
  localparam logic [CAW:0] COL_LIM = (CAW + 1)'(COLS);

  typedef logic [BPP-1:0] pix_t;

  // fb[front_sel] is scanned out; fb[~front_sel] takes writes.
  pix_t fb [2][ROWS][COLS];
  logic front_sel;
  logic swap_pending_q;

  logic [RAW-1:0] scan_row;
  logic [SW-1:0]  scan_slot;
  logic           is_blank;
  logic           frame_end;
  logic           frame_begin;

  led_scan_timer #(
    .ROWS        (ROWS),
    .BPP         (BPP),
    .PRESCALE    (PRESCALE),
    .BLANK_SLOTS (BLANK_SLOTS)
  ) u_timer (
    .clk12MHz    (clk12MHz),
    .reset_n     (reset_n),
    .enable      (enable),
    .row         (scan_row),
    .slot        (scan_slot),
    .is_blank    (is_blank),
    .frame_end   (frame_end),
    .frame_begin (frame_begin)
  );

  logic wr_hit;
  logic swap_want;
  logic swap_now;

  // Out-of-range addresses are dropped rather than aliased onto real pixels.
  assign wr_hit = bus.wr_en
                  && ({1'b0, bus.wr_row} < ROW_LIM)
                  && ({1'b0, bus.wr_col} < COL_LIM);

  // A request arriving on the frame-end clock is honoured at that boundary;
  // with the scan stopped there is no boundary to wait for.
  assign swap_want = swap_pending_q | bus.swap_req;
  assign swap_now  = swap_want & (frame_end | ~enable);

  assign bus.swap_pending = swap_pending_q;

  // Back-buffer write port. Indexed by the pre-swap selection, so a write on
  // the swap clock lands in the buffer that becomes the new front.
  always_ff @(posedge clk12MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            fb[b][r][c] <= '0;
          end
        end
      end
    end else if (wr_hit) begin
      fb[~front_sel][bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  // Swap bookkeeping: flip buffer roles, no copy; old front becomes back.
  always_ff @(posedge clk12MHz or negedge reset_n) begin
    if (!reset_n) begin
      front_sel      <= 1'b0;
      swap_pending_q <= 1'b0;
    end else if (swap_now) begin
      front_sel      <= ~front_sel;
      swap_pending_q <= 1'b0;
    end else begin
      swap_pending_q <= swap_want;
    end
  end

  logic [SW-1:0]   act_k;
  logic [ROWS-1:0] row_nxt;
  logic [COLS-1:0] col_nxt;

  // Active slot index; only meaningful outside the blanking slots.
  assign act_k = scan_slot - SW'(BLANK_SLOTS);

  // Pin pattern for the current scan position: a pixel of value v is lit
  // in active slots 0..v-1, so 0 never lights and full scale leaves one
  // dark slot per row.
  always_comb begin
    row_nxt = ROW_IDLE;
    col_nxt = COL_IDLE;
    if (enable && !is_blank) begin
      row_nxt[scan_row] = ~ROW_IDLE_BIT;
      for (int c = 0; c < COLS; c++) begin
        if (SW'(fb[front_sel][scan_row][c]) > act_k) begin
          col_nxt[c] = ~COL_IDLE_BIT;
        end
      end
    end
  end

  // Output registers; reset forces the pins idle without waiting for a clock.
  always_ff @(posedge clk12MHz or negedge reset_n) begin
    if (!reset_n) begin
      row_out     <= ROW_IDLE;
      col_out     <= COL_IDLE;
      frame_start <= 1'b0;
    end else begin
      row_out     <= row_nxt;
      col_out     <= col_nxt;
      frame_start <= frame_begin;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Testbench for led_matrix_scanner. A 4x8 instance with a short prescaler is
// compared every clock against a frame-position model; a 3x5 instance covers
// out-of-range writes and swapping while the scan is stopped.
module tb_led_matrix_scanner;

  localparam int ROWS        = 4;
  localparam int COLS        = 8;
  localparam int BPP         = 3;
  localparam int PRESCALE    = 2;
  localparam int BLANK_SLOTS = 1;
  localparam int LEVELS      = 1 << BPP;
  localparam int ROW_T       = PRESCALE * (BLANK_SLOTS + LEVELS);
  localparam int FRAME_T     = ROW_T * ROWS;
  localparam int RA_W        = $clog2(ROWS);
  localparam int CA_W        = $clog2(COLS);

  localparam int B_ROWS  = 3;
  localparam int B_COLS  = 5;
  localparam int B_SLOTS = 3;
  localparam int B_FRAME = B_ROWS * B_SLOTS;

  // ---------------- clock / reset ----------------
  logic clk12MHz = 1'b0;
  logic reset_n  = 1'b1;
  logic enable   = 1'b0;
  logic b_enable = 1'b0;

  always #5 clk12MHz = ~clk12MHz;

  // ---------------- DUTs ----------------
  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS), .BPP(BPP)) bus ();
  logic            frame_start;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_out;

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .BPP(BPP), .PRESCALE(PRESCALE),
    .BLANK_SLOTS(BLANK_SLOTS), .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk12MHz    (clk12MHz),
    .reset_n     (reset_n),
    .enable      (enable),
    .bus         (bus),
    .frame_start (frame_start),
    .row_out     (row_out),
    .col_out     (col_out)
  );

  led_matrix_scanner_if #(.ROWS(B_ROWS), .COLS(B_COLS), .BPP(1)) bus_b ();
  logic              b_frame_start;
  logic [B_ROWS-1:0] b_row_out;
  logic [B_COLS-1:0] b_col_out;

  led_matrix_scanner #(
    .ROWS(B_ROWS), .COLS(B_COLS), .BPP(1), .PRESCALE(1),
    .BLANK_SLOTS(1), .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk12MHz    (clk12MHz),
    .reset_n     (reset_n),
    .enable      (b_enable),
    .bus         (bus_b),
    .frame_start (b_frame_start),
    .row_out     (b_row_out),
    .col_out     (b_col_out)
  );

  // ---------------- reference model / scoreboard ----------------
  int m_buf [2][ROWS][COLS];
  int m_front;
  bit m_pending;
  int run_len;            // enabled edges since the scan last restarted
  int b_pix [B_ROWS][B_COLS];
  int b_run;
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) m_buf[b][r][c] = 0;
    m_front   = 0;
    m_pending = 0;
    run_len   = 0;
  endtask

  // One clock: predict the pins from the frame position, advance the model
  // by the rules for writes and swaps, then compare after the edge.
  task automatic tick();
    logic [ROWS-1:0] e_row;
    logic [COLS-1:0] e_col;
    logic            e_fs;
    int p, r, s, wr_r, wr_c;
    bit en_s, wr_s, sw_s;
    e_row = '1;
    e_col = '1;
    e_fs  = 1'b0;
    en_s  = enable;
    wr_s  = bus.wr_en;
    sw_s  = bus.swap_req;
    wr_r  = int'(bus.wr_row);
    wr_c  = int'(bus.wr_col);
    if (en_s) begin
      p    = run_len % FRAME_T;
      r    = p / ROW_T;
      s    = (p % ROW_T) / PRESCALE;
      e_fs = (p == 0);
      if (s >= BLANK_SLOTS) begin
        e_row[r] = 1'b0;
        for (int c = 0; c < COLS; c++)
          if (m_buf[m_front][r][c] > s - BLANK_SLOTS) e_col[c] = 1'b0;
      end
    end
    if (wr_s && wr_r < ROWS && wr_c < COLS)
      m_buf[1 - m_front][wr_r][wr_c] = int'(bus.wr_data);
    if (m_pending || sw_s) begin
      if (!en_s || (run_len % FRAME_T) == FRAME_T - 1) begin
        m_front   = 1 - m_front;
        m_pending = 0;
      end else begin
        m_pending = 1;
      end
    end
    run_len = en_s ? run_len + 1 : 0;
    @(posedge clk12MHz);
    #1;
    bus.wr_en      = 1'b0;
    bus.swap_req   = 1'b0;
    bus_b.wr_en    = 1'b0;
    bus_b.swap_req = 1'b0;
    check("row_out", 32'(row_out), 32'(e_row));
    check("col_out", 32'(col_out), 32'(e_col));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("swap_pending", 32'(bus.swap_pending), 32'(m_pending));
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_px(input int r, input int c, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_row  = RA_W'(r);
    bus.wr_col  = CA_W'(c);
    bus.wr_data = BPP'(d);
    tick();
  endtask

  task automatic write_b(input int r, input int c, input int d);
    bus_b.wr_en   = 1'b1;
    bus_b.wr_row  = 2'(r);
    bus_b.wr_col  = 3'(c);
    bus_b.wr_data = 1'(d);
    if (r < B_ROWS && c < B_COLS) b_pix[r][c] = d;
    tick();
  endtask

  // Advance until the next edge will show frame position 'target'.
  task automatic run_to(input int target);
    for (int g = 0; g < FRAME_T && (run_len % FRAME_T) != target; g++) tick();
    check("run_to_reached", 32'(run_len % FRAME_T), 32'(target));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lit0, lit1, lit3, pos;
    logic [B_ROWS-1:0] eb_row;
    logic [B_COLS-1:0] eb_col;
    int bp, br, bs;

    bus.wr_en = 1'b0;   bus.wr_row = '0;   bus.wr_col = '0;
    bus.wr_data = '0;   bus.swap_req = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_row = '0; bus_b.wr_col = '0;
    bus_b.wr_data = '0; bus_b.swap_req = 1'b0;
    model_reset();
    for (int r = 0; r < B_ROWS; r++)
      for (int c = 0; c < B_COLS; c++) b_pix[r][c] = 0;
    b_run = 0;

    // Reset state, before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    check("rst_row_out", 32'(row_out), 32'h0000_000F);
    check("rst_col_out", 32'(col_out), 32'h0000_00FF);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    check("rst_swap_pending", 32'(bus.swap_pending), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Empty frames: blanking, one-hot rows, frame_start every FRAME_T.
    enable = 1'b1;
    repeat (2 * FRAME_T) tick();

    // Pixel (1,3)=5 becomes visible only after the frame-boundary swap.
    write_px(1, 3, 5);
    bus.swap_req = 1'b1;
    tick();
    check("pending_after_req", 32'(bus.swap_pending), 32'h1);
    run_to(0);
    lit3 = 0;
    for (int i = 0; i < FRAME_T; i++) begin
      tick();
      if (col_out[3] === 1'b0) lit3++;
    end
    check("lit_clocks_px13", 32'(lit3), 32'(PRESCALE * 5));

    // Extreme values: 0 never lit, full scale lit all but one active slot.
    write_px(2, 0, 0);
    write_px(2, 1, LEVELS - 1);
    bus.swap_req = 1'b1;
    tick();
    run_to(0);
    lit0 = 0;
    lit1 = 0;
    for (int i = 0; i < FRAME_T; i++) begin
      tick();
      if (col_out[0] === 1'b0) lit0++;
      if (col_out[1] === 1'b0) lit1++;
    end
    check("lit_clocks_val0", 32'(lit0), 32'h0);
    check("lit_clocks_val7", 32'(lit1), 32'(PRESCALE * (LEVELS - 1)));

    // Write and swap request on the frame-end clock itself.
    run_to(FRAME_T - 1);
    bus.wr_en    = 1'b1;
    bus.wr_row   = RA_W'(0);
    bus.wr_col   = CA_W'(0);
    bus.wr_data  = BPP'(LEVELS - 1);
    bus.swap_req = 1'b1;
    tick();
    check("pending_coincident", 32'(bus.swap_pending), 32'h0);
    lit0 = 0;
    for (int i = 0; i < ROW_T; i++) begin
      tick();
      if (col_out[0] === 1'b0) lit0++;
    end
    check("lit_clocks_px00_row0", 32'(lit0), 32'(PRESCALE * (LEVELS - 1)));

    // A second request while one is pending yields a single swap.
    bus.swap_req = 1'b1;
    tick();
    repeat (5) tick();
    bus.swap_req = 1'b1;
    tick();
    check("pending_second_req", 32'(bus.swap_pending), 32'h1);
    run_to(0);
    check("pending_cleared", 32'(bus.swap_pending), 32'h0);
    repeat (FRAME_T) tick();

    // Random full frames written to the back buffer and swapped in.
    repeat (3) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          write_px(r, c, int'($urandom_range(0, LEVELS - 1)));
      bus.swap_req = 1'b1;
      tick();
      run_to(0);
      repeat (FRAME_T) tick();
    end

    // Drop enable mid-row 2, then restart from the top of the frame.
    pos = 2 * ROW_T + int'($urandom_range(2, ROW_T - 2));
    run_to(pos);
    enable = 1'b0;
    tick();
    check("disable_rows_idle", 32'(row_out), 32'h0000_000F);
    check("disable_cols_idle", 32'(col_out), 32'h0000_00FF);
    repeat (int'($urandom_range(3, 6))) tick();
    enable = 1'b1;
    tick();
    check("reenable_frame_start", 32'(frame_start), 32'h1);
    repeat (FRAME_T) tick();

    // Second instance: out-of-range writes dropped, swap while stopped.
    write_b(3, 0, 1);
    write_b(0, 5, 1);
    write_b(1, 7, 1);
    write_b(2, 4, 1);
    write_b(1, 2, 1);
    bus_b.swap_req = 1'b1;
    tick();
    check("b_swap_while_stopped", 32'(bus_b.swap_pending), 32'h0);
    b_enable = 1'b1;
    b_run    = 0;
    for (int i = 0; i < 2 * B_FRAME; i++) begin
      bp = b_run % B_FRAME;
      br = bp / B_SLOTS;
      bs = bp % B_SLOTS;
      eb_row = '1;
      eb_col = '1;
      if (bs >= 1) begin
        eb_row[br] = 1'b0;
        for (int c = 0; c < B_COLS; c++)
          if (b_pix[br][c] > bs - 1) eb_col[c] = 1'b0;
      end
      tick();
      b_run++;
      check("b_row_out", 32'(b_row_out), 32'(eb_row));
      check("b_col_out", 32'(b_col_out), 32'(eb_col));
      check("b_frame_start", 32'(b_frame_start), 32'(bp == 0));
    end
    b_enable = 1'b0;

    // Asynchronous reset in the middle of an active slot.
    run_to(ROW_T + 2 * PRESCALE);
    tick();
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_rows", 32'(row_out), 32'h0000_000F);
    check("async_rst_cols", 32'(col_out), 32'h0000_00FF);
    check("async_rst_pending", 32'(bus.swap_pending), 32'h0);
    check("b_async_rst_cols", 32'(b_col_out), 32'h0000_001F);
    model_reset();
    enable = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (FRAME_T) tick();
    // Both buffers must have been cleared: swap and expect a dark frame.
    bus.swap_req = 1'b1;
    tick();
    run_to(0);
    repeat (FRAME_T) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
